// File: rtl/layer2_flatten_if.sv
// ----------------------------------------------------------------------------
// layer2_flatten_if
//   Bundles the bank-read port and the flattened output stream of
//   layer2_flatten.
//   master : flatten engine side (drives rd_*, m_valid/m_data/m_index/m_last)
//   slave  : memory + dense-layer side (drives rd_data, m_ready)
//   Signals:
//     rd_en    bank read strobe
//     rd_ch    bank select (4 bits)
//     rd_addr  bank read address (ADDR_W)
//     rd_data  signed read data, valid 1 cycle after rd_en
//     m_valid  output element valid
//     m_ready  consumer accepts when m_valid && m_ready
//     m_data   signed element value
//     m_index  flat index (IDX_W)
//     m_last   final element marker
// ----------------------------------------------------------------------------
interface layer2_flatten_if #(
    parameter int ADDR_W = 8,
    parameter int IDX_W  = 10
);
    logic              rd_en;
    logic [3:0]        rd_ch;
    logic [ADDR_W-1:0] rd_addr;
    logic signed [7:0] rd_data;
    logic              m_valid;
    logic              m_ready;
    logic signed [7:0] m_data;
    logic [IDX_W-1:0]  m_index;
    logic              m_last;

    modport master (
        output rd_en, rd_ch, rd_addr,
        input  rd_data,
        output m_valid, m_data, m_index, m_last,
        input  m_ready
    );

    modport slave (
        input  rd_en, rd_ch, rd_addr,
        output rd_data,
        input  m_valid, m_data, m_index, m_last,
        output m_ready
    );
endinterface

// File: rtl/layer2_flatten.sv
// ----------------------------------------------------------------------------
// layer2_flatten
//   Reads the CH pooled POOL_W x POOL_W maps in place from the MAP_W x MAP_W
//   channel banks (pooled element (r,c) at 2*MAP_W*r + 2*c) and emits them as
//   one channel-major stream of signed bytes with a running flat index.
//   One element per 3 cycles (READ, WAIT, SEND) with m_ready held high.
//
//   Ports:
//     clk    clock
//     rst    asynchronous reset, active-low
//     start  one-cycle pulse; begins a scan when idle, ignored otherwise
//     bus    layer2_flatten_if.master (bank read port + output stream)
//     busy   high from the cycle after an accepted start until done
//     done   one-cycle pulse, the cycle after the m_last handshake
//
//   Optional feature macro: FLATTEN_ZERO_SKIP_EN
//     When defined, zero-valued elements other than the final one are not
//     emitted; m_index still carries the true flat index (sparse stream).
// ----------------------------------------------------------------------------
module layer2_flatten #(
    parameter int CH     = 16,
    parameter int MAP_W  = 14,
    parameter int POOL_W = 7,
    parameter int ADDR_W = 8,
    parameter int IDX_W  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    layer2_flatten_if.master bus,
    output logic             busy,
    output logic             done
);
    localparam int                PW       = $clog2(POOL_W);
    localparam logic [PW-1:0]     P_MAX    = PW'(POOL_W - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(2 * MAP_W);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(CH * POOL_W * POOL_W - 1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, FIN} state_t;

    state_t           state_q, state_d;
    logic [3:0]       ch_q, ch_nx;
    logic [PW-1:0]    r_q, r_nx;
    logic [PW-1:0]    c_q, c_nx;
    logic [IDX_W-1:0] idx_q;
    logic             skip;
    logic             handshake;

    assign handshake = (state_q == SEND) && bus.m_ready;

    // Next position in channel-major, row-major order.
    always_comb begin
        c_nx  = c_q + 1'b1;
        r_nx  = r_q;
        ch_nx = ch_q;
        if (c_q == P_MAX) begin
            c_nx = '0;
            if (r_q == P_MAX) begin
                r_nx  = '0;
                ch_nx = ch_q + 1'b1;
            end else begin
                r_nx = r_q + 1'b1;
            end
        end
    end

`ifdef FLATTEN_ZERO_SKIP_EN
    // The final element is always emitted so m_last/done are never lost.
    always_comb begin
        skip = (bus.rd_data == '0) && (idx_q != LAST_IDX);
    end
`else
    always_comb begin
        skip = 1'b0;
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = READ;
            READ:    state_d = WAIT;
            WAIT:    state_d = skip ? READ : SEND;
            SEND:    if (bus.m_ready) state_d = bus.m_last ? FIN : READ;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Read port is only driven while in READ, so no stray strobes or addresses.
    always_comb begin
        bus.rd_en   = (state_q == READ);
        bus.rd_ch   = (state_q == READ) ? ch_q : '0;
        bus.rd_addr = (state_q == READ) ?
                      (ROW_STEP * ADDR_W'(r_q)) + (ADDR_W'(c_q) << 1) : '0;
        done        = (state_q == FIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_q        <= '0;
            r_q         <= '0;
            c_q         <= '0;
            idx_q       <= '0;
            busy        <= 1'b0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_index <= '0;
            bus.m_last  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ch_q  <= '0;
                        r_q   <= '0;
                        c_q   <= '0;
                        idx_q <= '0;
                        busy  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (skip) begin
                        ch_q  <= ch_nx;
                        r_q   <= r_nx;
                        c_q   <= c_nx;
                        idx_q <= idx_q + 1'b1;
                    end else begin
                        bus.m_data  <= bus.rd_data;
                        bus.m_index <= idx_q;
                        bus.m_last  <= (idx_q == LAST_IDX);
                        bus.m_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        bus.m_valid <= 1'b0;
                        bus.m_last  <= 1'b0;
                        ch_q        <= ch_nx;
                        r_q         <= r_nx;
                        c_q         <= c_nx;
                        idx_q       <= idx_q + 1'b1;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    ch_q  <= '0;
                    r_q   <= '0;
                    c_q   <= '0;
                    idx_q <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_layer2_flatten.sv
module tb_layer2_flatten;
    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    layer2_flatten_if #(.ADDR_W(8), .IDX_W(10)) bus ();

    layer2_flatten #(
        .CH(16), .MAP_W(14), .POOL_W(7), .ADDR_W(8), .IDX_W(10)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Bank model: registered read, data valid the cycle after rd_en.
    logic [7:0] mem [16][256];
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_ch][bus.rd_addr];

    int n_vec = 0;
    int n_err = 0;

    int cyc = 0;
    int rd_cnt, bad_addr, beat_cnt, done_cnt, done_cyc;
    logic [7:0] b_data [1024];
    logic [9:0] b_idx  [1024];
    logic       b_last [1024];
    int         b_cyc  [1024];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (bus.rd_en) begin
            rd_cnt = rd_cnt + 1;
            if (bus.rd_addr > 8'd180) bad_addr = bad_addr + 1;
        end
        if (bus.m_valid && bus.m_ready) begin
            if (beat_cnt < 1024) begin
                b_data[beat_cnt] = bus.m_data;
                b_idx[beat_cnt]  = bus.m_index;
                b_last[beat_cnt] = bus.m_last;
                b_cyc[beat_cnt]  = cyc;
            end
            beat_cnt = beat_cnt + 1;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        rd_cnt = 0; bad_addr = 0; beat_cnt = 0; done_cnt = 0; done_cyc = -1;
    endtask

    task automatic fill_std();
        for (int k = 0; k < 16; k++)
            for (int a = 0; a < 256; a++) mem[k][a] = 8'h7F;
        for (int k = 0; k < 16; k++)
            for (int r = 0; r < 7; r++)
                for (int c = 0; c < 7; c++) mem[k][28*r + 2*c] = 8'(k + 1);
        mem[2][94] = 8'hF9;  // ch 2, (r=3,c=5) = -7
    endtask

    // Called at posedge+1 in an idle cycle; first rd_en must follow one cycle later.
    task automatic do_start(input string tag);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_rd_en_after_start"}, 32'(bus.rd_en), 32'd1);
        chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_done_timeout"}, 32'(done_cnt == 0), 32'd0);
    endtask

    task automatic wait_beats(input int target, input string tag);
        int n;
        n = 0;
        while (beat_cnt < target && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_beat_timeout"}, 32'(beat_cnt < target), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rd"},  32'({bus.rd_en, bus.rd_ch, bus.rd_addr}), 32'd0);
        chk({tag, "_m"},   32'({bus.m_valid, bus.m_data, bus.m_index, bus.m_last}), 32'd0);
        chk({tag, "_ctl"}, 32'({busy, done}), 32'd0);
    endtask

    function automatic int dense_errs();
        int e;
        logic [7:0] ed;
        e = 0;
        for (int i = 0; i < 784; i++) begin
            ed = (i == 124) ? 8'hF9 : 8'(i / 49 + 1);
            if (b_data[i] !== ed || b_idx[i] !== 10'(i) || b_last[i] !== (i == 783)) e++;
        end
        return e;
    endfunction

    function automatic int gap_errs();
        int e;
        e = 0;
        for (int i = 1; i < 784; i++) if (b_cyc[i] - b_cyc[i-1] != 3) e++;
        return e;
    endfunction

    task automatic check_dense_scan(input string tag);
        chk({tag, "_beats"},     32'(beat_cnt), 32'd784);
        chk({tag, "_content"},   32'(dense_errs()), 32'd0);
        chk({tag, "_gaps"},      32'(gap_errs()), 32'd0);
        chk({tag, "_done_cnt"},  32'(done_cnt), 32'd1);
        chk({tag, "_done_cyc"},  32'(done_cyc), 32'(b_cyc[783] + 1));
        chk({tag, "_rd_cnt"},    32'(rd_cnt), 32'd784);
        chk({tag, "_bad_addr"},  32'(bad_addr), 32'd0);
        chk({tag, "_busy_end"},  32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] d0;
        logic [9:0] i0;
        int n;

        rst = 1'b0; start = 1'b0; bus.m_ready = 1'b0; bus.rd_data = '0;
        fill_std();
        clear_stats();
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_outputs_zero("idle");

        // Stall on beat 0, then full scan.
        clear_stats();
        do_start("s1");
        n = 0;
        while (!bus.m_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("s1_first_valid", 32'(bus.m_valid), 32'd1);
        d0 = bus.m_data;
        i0 = bus.m_index;
        chk("s1_beat0_data", 32'(d0), 32'd1);
        chk("s1_beat0_index", 32'(i0), 32'd0);
        chk("s1_beat0_last", 32'(bus.m_last), 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_valid", 32'(bus.m_valid), 32'd1);
            chk("stall_data", 32'(bus.m_data), 32'd1);
            chk("stall_index", 32'(bus.m_index), 32'd0);
        end
        chk("stall_no_new_rd", 32'(rd_cnt), 32'd1);
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        wait_done("s1");
        check_dense_scan("s1");
        chk("s1_beat124_data", 32'(b_data[124]), 32'hF9);
        chk("s1_beat124_index", 32'(b_idx[124]), 32'd124);

        // Back-to-back: start in the cycle right after done.
        clear_stats();
        do_start("b2b");
        wait_done("b2b");
        check_dense_scan("b2b");

        // Start pulsed mid-scan is ignored.
        @(posedge clk); #1;
        clear_stats();
        do_start("mid");
        wait_beats(100, "mid");
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("mid");
        check_dense_scan("mid");

        // Reset at beat 300 aborts with no done.
        @(posedge clk); #1;
        clear_stats();
        do_start("abort");
        wait_beats(300, "abort");
        rst = 1'b0;
        #1;
        check_outputs_zero("abort");
        chk("abort_beats", 32'(beat_cnt), 32'd300);
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("abort_hold");
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // Fresh scan after the abort.
        clear_stats();
        do_start("after");
        wait_done("after");
        check_dense_scan("after");

`ifdef FLATTEN_ZERO_SKIP_EN
        // Sparse stream: only ch0(0,0) is nonzero; the final element is still sent.
        for (int k = 0; k < 16; k++)
            for (int a = 0; a < 256; a++) mem[k][a] = 8'h00;
        mem[0][0] = 8'd5;
        @(posedge clk); #1;
        clear_stats();
        do_start("skip");
        wait_done("skip");
        chk("skip_beats", 32'(beat_cnt), 32'd2);
        chk("skip_b0", 32'({b_idx[0], b_data[0], b_last[0]}), 32'({10'd0, 8'd5, 1'b0}));
        chk("skip_b1", 32'({b_idx[1], b_data[1], b_last[1]}), 32'({10'd783, 8'd0, 1'b1}));
        chk("skip_done_cyc", 32'(done_cyc), 32'(b_cyc[1] + 1));
        chk("skip_rd_cnt", 32'(rd_cnt), 32'd784);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
